// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package riscv_mem_pkg;

  localparam int WORD_W              = 32;
  localparam int BE_W                = WORD_W / 8;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port synchronous word array; one access per enabled cycle,
// registered read data held until the next enabled read.
module dmem_array
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready data-memory responder with a fixed number of wait states per access.
// Optional macro DMEM_MISALIGN_CHECK_EN flags addresses with addr[1:0] != 0 as errors.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              accept, access, in_idle;
  logic              range_err, addr_err;
  logic              we_q, err_q;
  logic [AW-1:0]     word_q;
  logic [WORD_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              arr_en, arr_we, arr_err;
  logic [AW-1:0]     arr_word;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;
  logic [BE_W-1:0]   arr_be;

  assign range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign addr_err = range_err | (req_addr[1:0] != 2'b00);
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[1:0];
  assign addr_err        = range_err;
`endif

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
          access     = (WAIT_CYCLES == 0);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
          access     = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      err_q   <= addr_err;
      word_q  <= req_addr[AW+1:2];
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // With zero wait states the access coincides with accept, so feed the live request.
  assign in_idle   = (state == IDLE);
  assign arr_we    = in_idle ? req_we    : we_q;
  assign arr_err   = in_idle ? addr_err  : err_q;
  assign arr_word  = in_idle ? req_addr[AW+1:2] : word_q;
  assign arr_wdata = in_idle ? req_wdata : wdata_q;
  assign arr_be    = in_idle ? req_be    : be_q;
  assign arr_en    = access & ~reset & ~arr_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_word),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) & err_q;
  assign resp_rdata = (state == RESP && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states between accept and response (range 0-15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  byte enables for stores; bit i enables byte i.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  core accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  access error flag, valid with resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-017 Accept SHALL occur on a cycle with req_valid=1 and req_ready=1; we/addr/wdata/be SHALL be captured that cycle.
REQ-018 On accept: if WAIT_CYCLES=0, next state RESP; otherwise WAIT, with the down-counter loaded to WAIT_CYCLES-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 0 the next state SHALL be RESP.
REQ-020 The array access SHALL occur on the transition into RESP: store writes the enabled bytes; load registers the word at addr[31:2] into resp_rdata.
REQ-021 Accept-to-resp_valid latency SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-022 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1.
REQ-023 RESP with resp_ready=1 SHALL return to IDLE; a new request can be accepted no earlier than the following cycle.
REQ-024 An address with addr[31:2] >= DEPTH_WORDS SHALL set resp_err=1, suppress the write, and give resp_rdata=0.
REQ-025 A store with req_be=0000 SHALL complete with resp_err=0 and leave the array unchanged.
REQ-026 req_valid while not in IDLE SHALL be ignored; no second request SHALL be queued.

Reset
REQ-027 reset=1 SHALL force state IDLE, counter 0, resp_valid=0, resp_err=0, resp_rdata=0; req_ready SHALL be 1 in the cycle after reset.
REQ-028 reset during WAIT or RESP SHALL abandon the transaction; a store not yet written SHALL NOT modify the array.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Misalignment checking SHALL be controlled by macro DMEM_MISALIGN_CHECK_EN.
REQ-031 With DMEM_MISALIGN_CHECK_EN defined, req_addr[1:0] != 0 SHALL produce resp_err=1, with no write and resp_rdata=0.
REQ-032 Without DMEM_MISALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and the access SHALL proceed on the word at addr[31:2].

Structure
REQ-033 Package riscv_mem_pkg SHALL hold the FSM state enum, the word/byte-enable width constants and the default WAIT_CYCLES.
REQ-034 The storage SHALL be a sub-module dmem_array: a byte-enabled single-port synchronous array of DEPTH_WORDS x 32.

Verification
REQ-035 Store: addr 0x10, data 0xDEADBEEF, be 1111, WAIT_CYCLES=2. Required: resp_valid 3 cycles after accept, resp_err=0. Then load 0x10 must return 0xDEADBEEF.
REQ-036 Partial store: 0x12345678 written at 0x10 with be 0011 over 0xDEADBEEF. Required: load 0x10 returns 0xDEAD5678.
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles in RESP. Required: resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0.
REQ-038 Out of range: DEPTH_WORDS=1024, store to 0x1000. Required: resp_err=1 and word 0 remains unchanged.
REQ-039 Reset in WAIT during a store of 0xCAFEF00D to 0x20. Required: next cycle resp_valid=0 and req_ready=1, and load 0x20 returns the prior value.
REQ-040 Load 0x22. Required: with DMEM_MISALIGN_CHECK_EN, resp_err=1 and rdata 0; without it, the word at 0x20 is returned with resp_err=0.
